// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and default timing constants for the stopwatch controller.
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
  localparam int DEBOUNCE_TICKS_DEF = 2;
  localparam int REFRESH_TICKS_DEF = 10;
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes a raw button, debounces it on the 100 Hz tick and emits a one-clk press event.
module button_conditioner #(
  parameter int DEBOUNCE_TICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic btn_i,
  output logic ev_o
);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  logic [1:0] sync_q;
  logic level_q, level_d, ev_q, ev_d, last;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    last = cnt_q == CW'(DEBOUNCE_TICKS - 1);
    cnt_d = tick_i ? ((sync_q[1] == level_q || last) ? '0 : cnt_q + 1'b1) : cnt_q;
    level_d = (tick_i && sync_q[1] != level_q && last) ? sync_q[1] : level_q;
    ev_d = level_d & ~level_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      level_q <= 1'b0;
      cnt_q <= '0;
      ev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q <= cnt_d;
      ev_q <= ev_d;
    end
  end
  assign ev_o = ev_q;
endmodule

// File: rtl/stopwatch_controller.sv
// stopwatch_controller: button-driven run/pause/lap FSM gating the 100 Hz tick into the counter chain
// and scheduling display updates over a req/ack handshake.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int REFRESH_TICKS = REFRESH_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_100hz,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       counter_enable,
  output logic       counter_clear,
  output logic       display_enable,
  output logic       disp_req,
  input  logic       disp_ack,
  output logic [1:0] state_o
);
  localparam int RW = $clog2(REFRESH_TICKS + 1);
  state_t state_q, state_d;
  logic ev_ss, ev_lr_raw, ev_lr;
  logic en_q, en_d, clr_q, clr_d, disp_en_q, disp_en_d;
  logic req_q, req_d, pend_q, pend_d;
  logic trans, run_tick, wrap;
  logic [RW-1:0] ref_q, ref_d;
  button_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_ss (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_100hz), .btn_i(btn_start_stop), .ev_o(ev_ss)
  );
  button_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_lr (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_100hz), .btn_i(btn_lap_reset), .ev_o(ev_lr_raw)
  );
  // start/stop has priority when both presses land in the same cycle
  assign ev_lr = ev_lr_raw & ~ev_ss;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q <= 1'b0;
      clr_q <= 1'b0;
      disp_en_q <= 1'b1;
      req_q <= 1'b0;
      pend_q <= 1'b1;
      ref_q <= '0;
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      clr_q <= clr_d;
      disp_en_q <= disp_en_d;
      req_q <= req_d;
      pend_q <= pend_d;
      ref_q <= ref_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = ev_ss ? RUN : IDLE;
      RUN:   state_d = ev_ss ? PAUSE : ev_lr ? LAP : RUN;
      LAP:   state_d = ev_ss ? PAUSE : ev_lr ? RUN : LAP;
      PAUSE: state_d = ev_ss ? RUN : ev_lr ? IDLE : PAUSE;
    endcase
  end
  always_comb begin
    trans = state_d != state_q;
    run_tick = tick_100hz && state_q == RUN;
    wrap = run_tick && !trans && ref_q == RW'(REFRESH_TICKS - 1);
    ref_d = (trans || wrap) ? '0 : run_tick ? ref_q + 1'b1 : ref_q;
    en_d = tick_100hz && (state_q == RUN || state_q == LAP);
    clr_d = ev_lr && (state_q == IDLE || state_q == PAUSE);
    disp_en_d = state_d != LAP;
    // pending stays up while a request is outstanding, so later updates merge into it
    pend_d = trans || clr_d || wrap || (pend_q && !(req_q && disp_ack));
    req_d = req_q ? !disp_ack : pend_q;
  end
  assign counter_enable = en_q;
  assign counter_clear = clr_q;
  assign display_enable = disp_en_q;
  assign disp_req = req_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_stopwatch_controller.sv
// tb_stopwatch_controller: directed checks of the stopwatch control FSM, debounce, counter gating and display handshake.
module tb_stopwatch_controller;
  import stopwatch_pkg::*;
  localparam int TP = 20;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, btn_ss = 1'b0, btn_lr = 1'b0;
  logic auto_ack = 1'b1, ack_auto = 1'b0, ack_man = 1'b0;
  logic disp_ack, counter_enable, counter_clear, display_enable, disp_req;
  logic [1:0] state_o;
  int n_tests = 0, n_fail = 0;
  int en_cnt = 0, bad_en = 0, req_rises = 0, clr_cnt = 0;
  int en_b, req_b, clr_b;
  logic tick_prev = 1'b0, req_prev = 1'b0;

  assign disp_ack = auto_ack ? ack_auto : ack_man;
  always #5 clk = ~clk;

  stopwatch_controller dut (
    .clk(clk), .rst_n(rst_n), .tick_100hz(tick), .btn_start_stop(btn_ss), .btn_lap_reset(btn_lr),
    .counter_enable(counter_enable), .counter_clear(counter_clear), .display_enable(display_enable),
    .disp_req(disp_req), .disp_ack(disp_ack), .state_o(state_o)
  );

  initial forever begin
    repeat (TP - 1) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (auto_ack && disp_req) begin
      repeat (2) @(posedge clk);
      #1 ack_auto = 1'b1;
      @(posedge clk);
      #1 ack_auto = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (counter_enable) begin
      en_cnt++;
      if (!tick_prev) bad_en++;
    end
    if (disp_req && !req_prev) req_rises++;
    if (counter_clear) clr_cnt++;
    tick_prev = tick;
    req_prev = disp_req;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!tick);
    end
  endtask

  task automatic press(input logic ss, input logic lr);
    wait_ticks(3);
    #1;
    btn_ss = ss;
    btn_lr = lr;
    wait_ticks(2);
    @(posedge clk);
    step();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_state", state_o, 2'b00);
    chk("rst_disp_en", display_enable, 1);
    chk("rst_req", disp_req, 0);
    chk("rst_en", counter_enable, 0);
    chk("rst_clr", counter_clear, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("req_before_rise", disp_req, 0);
    step();
    chk("req_rise", disp_req, 1);
    repeat (2) step();
    chk("req_held_at_ack", disp_req, 1);
    step();
    chk("req_fall_after_ack", disp_req, 0);
    wait_ticks(3);
    step();
    chk("idle_no_en", en_cnt, 0);
    chk("idle_state", state_o, 2'b00);
    chk("idle_disp_en", display_enable, 1);

    press(1'b1, 1'b0);
    chk("run_entry", state_o, 2'b01);
    repeat (8) step();
    en_b = en_cnt;
    req_b = req_rises;
    wait_ticks(25);
    step();
    chk("run_en_count", en_cnt - en_b, 25);
    chk("run_en_timing", bad_en, 0);
    chk("run_refresh_reqs", req_rises - req_b, 2);

    wait_ticks(1);
    #1;
    for (int i = 0; i < 15; i++) begin
      btn_ss = ~btn_ss;
      @(posedge clk);
      #1;
    end
    btn_ss = 1'b0;
    wait_ticks(3);
    step();
    chk("bounce_no_change", state_o, 2'b01);

    press(1'b0, 1'b1);
    chk("lap_state", state_o, 2'b11);
    chk("lap_disp_en", display_enable, 0);
    repeat (8) step();
    en_b = en_cnt;
    req_b = req_rises;
    wait_ticks(12);
    step();
    chk("lap_en_continues", en_cnt - en_b, 12);
    chk("lap_no_refresh", req_rises - req_b, 0);
    req_b = req_rises;
    press(1'b0, 1'b1);
    chk("unlap_state", state_o, 2'b01);
    chk("unlap_disp_en", display_enable, 1);
    repeat (8) step();
    chk("unlap_one_req", req_rises - req_b, 1);

    press(1'b1, 1'b0);
    chk("pause_state", state_o, 2'b10);
    repeat (8) step();
    req_b = req_rises;
    clr_b = clr_cnt;
    press(1'b0, 1'b1);
    chk("clear_state", state_o, 2'b00);
    chk("clear_pulse", counter_clear, 1);
    step();
    chk("clear_gone", counter_clear, 0);
    repeat (8) step();
    chk("clear_width", clr_cnt - clr_b, 1);
    chk("clear_one_req", req_rises - req_b, 1);

    press(1'b1, 1'b0);
    chk("rerun_state", state_o, 2'b01);
    repeat (8) step();
    press(1'b1, 1'b1);
    chk("both_ss_wins", state_o, 2'b10);
    repeat (8) step();
    chk("both_no_lap", state_o, 2'b10);

    auto_ack = 1'b0;
    req_b = req_rises;
    press(1'b1, 1'b0);
    wait_ticks(12);
    press(1'b0, 1'b1);
    chk("merge_state", state_o, 2'b11);
    chk("merge_req_held", disp_req, 1);
    chk("merge_single_req", req_rises - req_b, 1);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    chk("merge_req_drop", disp_req, 0);
    repeat (10) step();
    chk("merge_no_extra", req_rises - req_b, 1);
    press(1'b0, 1'b1);
    repeat (3) step();
    chk("pre_reset_req", disp_req, 1);
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", disp_req, 0);
    chk("async_state", state_o, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    auto_ack = 1'b1;
    step();
    step();
    chk("post_reset_req", disp_req, 1);
    repeat (10) step();
    chk("post_reset_done", disp_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
